// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
// Optional alignment checking is enabled with the LSU_ALIGN_CHECK_EN macro.
package lsu_pkg;

   localparam int LSU_ADDR_W      = 64;
   localparam int LSU_DATA_W      = 64;
   localparam int LSU_MEM_LATENCY = 1;
   localparam int LSU_CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_wait_counter.sv
// Load/decrement counter that times the memory latency window.
// is_one marks the final wait cycle, when load data is valid.
module lsu_wait_counter
   import lsu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 dec,
   input  logic [LSU_CNT_W-1:0] load_val,
   output logic                 is_one
);

   logic [LSU_CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign is_one = (count == LSU_CNT_W'(1));

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> WAIT -> RESP.
// Define LSU_ALIGN_CHECK_EN to fault misaligned requests without a memory access.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W      = LSU_ADDR_W,
   parameter int DATA_W      = LSU_DATA_W,
   parameter int MEM_LATENCY = LSU_MEM_LATENCY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ReqValid,
   input  logic              ReqWrite,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [DATA_W-1:0] ReqWData,
   output logic              ReqReady,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [DATA_W-1:0] MemWriteData,
   output logic              MemRead,
   output logic              MemWrite,
   input  logic [DATA_W-1:0] MemReadData,
   output logic              RespValid,
   output logic [DATA_W-1:0] RespData,
   output logic              RespFault,
   output logic              Busy,
   output lsu_state_t        dbg_state
);

   // Handshake: a request transfers on a cycle where ReqValid && ReqReady;
   // ReqValid while not ready is dropped, and RespValid is a single-cycle pulse.

   localparam logic [LSU_CNT_W-1:0] LAT_INIT = LSU_CNT_W'(MEM_LATENCY);

   lsu_state_t        state, state_nx;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] resp_data_q;
   logic              accept;
   logic              misaligned;
   logic              capture;
   logic              wait_last;

   assign accept  = ReqValid && (state == IDLE);
   assign capture = (state == WAIT) && wait_last && !write_q;

`ifdef LSU_ALIGN_CHECK_EN
   logic fault_q;
   assign misaligned = (ReqAddr[2:0] != 3'b000);
   assign RespFault  = (state == RESP) && fault_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else if (accept) begin
         fault_q <= misaligned;
      end
   end
`else
   assign misaligned = 1'b0;
   assign RespFault  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = misaligned ? RESP : ACCESS;
         ACCESS:  state_nx = WAIT;
         WAIT:    if (wait_last) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request latches double as the memory-side address/data, so they hold until the next accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         resp_data_q <= '0;
      end else begin
         if (accept) begin
            write_q <= ReqWrite;
            addr_q  <= ReqAddr;
            wdata_q <= ReqWData;
         end
         if (capture) begin
            resp_data_q <= MemReadData;
         end
      end
   end

   lsu_wait_counter u_wait_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == ACCESS),
      .dec      (state == WAIT),
      .load_val (LAT_INIT),
      .is_one   (wait_last)
   );

   assign ReqReady     = (state == IDLE);
   assign Busy         = (state != IDLE);
   assign MemRead      = (state == ACCESS) && !write_q;
   assign MemWrite     = (state == ACCESS) && write_q;
   assign MemAddress   = addr_q;
   assign MemWriteData = wdata_q;
   assign RespValid    = (state == RESP);
   assign RespData     = resp_data_q;
   assign dbg_state    = state;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 64, byte-address width.
REQ-002 Parameter DATA_W, default 64, doubleword data width.
REQ-003 Parameter MEM_LATENCY, default 1, legal range 1..15; cycles from memory strobe to read data being valid.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 ReqValid  in  1  pipeline requests an access.
REQ-007 ReqWrite  in  1  1 = store (STUR), 0 = load (LDUR).
REQ-008 ReqAddr  in  ADDR_W  byte address.
REQ-009 ReqWData  in  DATA_W  store data.
REQ-010 ReqReady  out  1  unit can accept a request.
REQ-011 MemAddress  out  ADDR_W  address driven to data memory.
REQ-012 MemWriteData  out  DATA_W  store data driven to data memory.
REQ-013 MemRead  out  1  one-cycle read strobe.
REQ-014 MemWrite  out  1  one-cycle write strobe.
REQ-015 MemReadData  in  DATA_W  data returned by memory.
REQ-016 RespValid  out  1  one-cycle completion pulse.
REQ-017 RespData  out  DATA_W  load result.
REQ-018 RespFault  out  1  request completed without memory access due to misalignment.
REQ-019 Busy  out  1  a request is in flight (state != IDLE).

Function
REQ-020 FSM states: IDLE, ACCESS, WAIT, RESP.
REQ-021 ReqReady = 1 only in IDLE; a request is accepted on a cycle with ReqValid && ReqReady, latching ReqWrite, ReqAddr, ReqWData.
REQ-022 IDLE -> ACCESS on acceptance; ReqValid while not ready is ignored, not queued.
REQ-023 ACCESS lasts exactly 1 cycle: MemRead (load) or MemWrite (store) = 1; MemAddress/MemWriteData are driven from the latches; wait counter loaded with MEM_LATENCY; -> WAIT.
REQ-024 WAIT decrements the counter each cycle; on the cycle the counter equals 1, a load captures MemReadData into RespData; -> RESP.
REQ-025 RESP lasts 1 cycle: RespValid = 1; -> IDLE.
REQ-026 Latency: acceptance at cycle T gives the strobe at T+1 and RespValid at T+2+MEM_LATENCY-1+1 = T+MEM_LATENCY+2.
REQ-027 MemRead and MemWrite are never both 1; both are 0 outside ACCESS.
REQ-028 MemAddress and MemWriteData hold their latched values from ACCESS until the next acceptance.
REQ-029 RespData holds its value until the next load capture; a store completion leaves RespData unchanged.
REQ-030 RespFault is valid only with RespValid and is 0 otherwise.
REQ-031 A new request may be accepted in the cycle after RESP (IDLE); back-to-back throughput is one request per MEM_LATENCY+3 cycles.

Reset
REQ-032 While rst_n = 0 at a clock edge: state -> IDLE, counter -> 0, MemRead = MemWrite = RespValid = RespFault = 0, MemAddress = MemWriteData = RespData = 0, Busy = 0.
REQ-033 Reset in any state aborts the request; no strobe or RespValid follows; ReqReady = 1 on the first cycle after rst_n returns to 1.

Configuration
REQ-034 Macro LSU_ALIGN_CHECK_EN defined: an accepted request with ReqAddr[2:0] != 0 goes IDLE -> RESP directly, with no MemRead/MemWrite; RespValid = 1 and RespFault = 1 at T+1; RespData is unchanged.
REQ-035 Macro LSU_ALIGN_CHECK_EN undefined: no alignment check; RespFault is tied to 0; all requests take the ACCESS/WAIT path.

Structure
REQ-036 Shared package lsu_pkg holds the FSM state enum typedef, ADDR_W/DATA_W defaults, and the default MEM_LATENCY constant.
REQ-037 One sub-module, lsu_wait_counter (4-bit load/decrement counter with an is-one flag), is instantiated for WAIT timing.

Verification
REQ-038 Reset: hold rst_n = 0 for 3 cycles, then release -> all outputs 0, ReqReady = 1, Busy = 0.
REQ-039 Store then load, MEM_LATENCY = 1: store 0xDEAD_BEEF_0000_0010 to 0x40, then load 0x40 -> one MemWrite pulse, one MemRead pulse, RespData = 0xDEAD_BEEF_0000_0010, RespValid 3 cycles after each acceptance.
REQ-040 MEM_LATENCY = 4: load accepted at T -> MemRead at T+1, RespValid at T+6; ReqValid held high during Busy -> no second accept until IDLE.
REQ-041 Misaligned load to 0x43 with LSU_ALIGN_CHECK_EN -> no strobe, RespFault = 1 at T+1; without the macro -> normal access and RespFault = 0.
REQ-042 Reset asserted in WAIT -> no RespValid ever issued for that request; the next request completes normally.
